pixel_plot_sink: RTL and testbench

//  Receiving end of the pixel-plot interface our draw datapaths drive: it accepts (x, y, colour, plot)

---
 rtl/theremin_vga_pkg.sv | 42 ++++
 rtl/pixel_fifo.sv | 69 ++++++
 rtl/pixel_plot_sink.sv | 184 ++++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/theremin_vga_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer write path.
// Holds screen geometry, colour constants, the sink FSM state enum, the
// plot request payload and the linear address / visibility helpers.
package theremin_vga_pkg;

   localparam int unsigned H_RES      = 320;
   localparam int unsigned V_RES      = 240;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned ADDR_W     = 17;
   localparam int unsigned COLOUR_W   = 3;
   localparam int unsigned X_W        = 9;
   localparam int unsigned Y_W        = 8;
   localparam int unsigned DROP_W     = 8;
   localparam int unsigned FB_WORDS   = H_RES * V_RES;

   localparam logic [COLOUR_W-1:0] WHITE = COLOUR_W'(7);
   localparam logic [COLOUR_W-1:0] BLACK = COLOUR_W'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FILL  = 2'd2,
      S_DONE  = 2'd3
   } sink_state_e;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] colour;
   } plot_req_t;

   // True when the request lands inside the visible area.
   function automatic logic on_screen(input plot_req_t r);
      return (r.x < X_W'(H_RES)) && (r.y < Y_W'(V_RES));
   endfunction

   // y*320 + x as two shifts and an add; result fits ADDR_W for visible pixels.
   function automatic logic [ADDR_W-1:0] pixel_addr(input plot_req_t r);
      return (ADDR_W'(r.y) << 8) + (ADDR_W'(r.y) << 6) + ADDR_W'(r.x);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO buffering plot requests.
// Ports: clock/reset (sync, active-high); push/wdata write side; pop/rdata_c
// read side (rdata_c shows the head entry); empty_c/full_c flags and count
// (entries currently held). Push and pop may coincide when full or empty.
module pixel_fifo #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rdata_c,
   output logic                    empty_c,
   output logic                    full_c,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_c, pop_ok_c;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign rdata_c = mem_q[rd_ptr_q];
   assign count   = count_q;

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   always_comb begin
      push_ok_c = push && (!full_c || pop);
      pop_ok_c  = pop && !empty_c;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push_ok_c) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pixel_plot_sink.sv
// Framebuffer write sink for the pixel-plot interface.
// Accepts (x, y, colour) plot requests into a small FIFO, converts visible
// pixels to linear addresses and writes them to the 320x240 3-bit framebuffer,
// counting and discarding off-screen pixels. A fill command drains pending
// plots, then paints every address with one colour.
// Ports: clock/reset (sync, active-high); plot/plotX/plotY/plotColour/plotReady
// request handshake; fillStart/fillColour/fillBusy/fillDone fill control;
// memAddress/memData/memWren framebuffer write port; dropCount off-screen count.
module pixel_plot_sink
   import theremin_vga_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                plot,
   input  logic [X_W-1:0]      plotX,
   input  logic [Y_W-1:0]      plotY,
   input  logic [COLOUR_W-1:0] plotColour,
   output logic                plotReady,
   input  logic                fillStart,
   input  logic [COLOUR_W-1:0] fillColour,
   output logic                fillBusy,
   output logic                fillDone,
   output logic [ADDR_W-1:0]   memAddress,
   output logic [COLOUR_W-1:0] memData,
   output logic                memWren,
   output logic [DROP_W-1:0]   dropCount
);

   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned REQ_W     = $bits(plot_req_t);
   localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_WORDS - 1);

   sink_state_e         state_q, state_d;
   logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;
   logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic                fill_busy_q, fill_busy_d;
   logic                fill_done_q, fill_done_d;
   logic                plot_ready_q, plot_ready_d;
   logic                stage_valid_q, stage_valid_d;
   plot_req_t           stage_req_q, stage_req_d;
   logic                mem_wren_q, mem_wren_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

   plot_req_t           push_req_c;
   plot_req_t           fifo_head_c;
   logic [REQ_W-1:0]    fifo_rdata_c;
   logic                fifo_push_c, fifo_pop_c;
   logic                fifo_empty_c, fifo_full_c;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W-1:0]    fifo_cnt_next_c;

   assign push_req_c  = '{x: plotX, y: plotY, colour: plotColour};
   assign fifo_head_c = plot_req_t'(fifo_rdata_c);

   pixel_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (fifo_push_c),
      .wdata   (REQ_W'(push_req_c)),
      .pop     (fifo_pop_c),
      .rdata_c (fifo_rdata_c),
      .empty_c (fifo_empty_c),
      .full_c  (fifo_full_c),
      .count   (fifo_count)
   );

   // Next-state, address stage, write port and fill sequencing.
   always_comb begin
      state_d       = state_q;
      fill_colour_d = fill_colour_q;
      fill_cnt_d    = fill_cnt_q;
      fill_busy_d   = fill_busy_q;
      fill_done_d   = 1'b0;
      stage_valid_d = 1'b0;
      stage_req_d   = stage_req_q;
      drop_cnt_d    = drop_cnt_q;
      mem_wren_d    = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_d    = mem_data_q;

      fifo_push_c = plot && plot_ready_q && !fifo_full_c;
      fifo_pop_c  = !fifo_empty_c;

      // Visibility is decided as the head leaves the FIFO; drops leave a bubble.
      if (fifo_pop_c) begin
         if (on_screen(fifo_head_c)) begin
            stage_valid_d = 1'b1;
            stage_req_d   = fifo_head_c;
         end else if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
         end
      end

      if (stage_valid_q) begin
         mem_wren_d = 1'b1;
         mem_addr_d = pixel_addr(stage_req_q);
         mem_data_d = stage_req_q.colour;
      end

      case (state_q)
         S_IDLE: begin
            // fillBusy drops the cycle after the fillDone pulse.
            if (fill_done_q) begin
               fill_busy_d = 1'b0;
            end
            if (fillStart) begin
               fill_colour_d = fillColour;
               fill_busy_d   = 1'b1;
               state_d       = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fifo_empty_c && !stage_valid_q) begin
               fill_cnt_d = '0;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            mem_wren_d = 1'b1;
            mem_addr_d = fill_cnt_q;
            mem_data_d = fill_colour_q;
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
            if (fill_cnt_q == FILL_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            fill_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered ready reflects next-cycle state and occupancy.
      fifo_cnt_next_c = fifo_count + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
      plot_ready_d    = (state_d == S_IDLE) && (fifo_cnt_next_c != CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         fill_colour_q <= BLACK;
         fill_cnt_q    <= '0;
         fill_busy_q   <= 1'b0;
         fill_done_q   <= 1'b0;
         plot_ready_q  <= 1'b0;
         stage_valid_q <= 1'b0;
         stage_req_q   <= '0;
         mem_wren_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_q    <= BLACK;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fill_colour_q <= fill_colour_d;
         fill_cnt_q    <= fill_cnt_d;
         fill_busy_q   <= fill_busy_d;
         fill_done_q   <= fill_done_d;
         plot_ready_q  <= plot_ready_d;
         stage_valid_q <= stage_valid_d;
         stage_req_q   <= stage_req_d;
         mem_wren_q    <= mem_wren_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_q    <= mem_data_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign plotReady  = plot_ready_q;
   assign fillBusy   = fill_busy_q;
   assign fillDone   = fill_done_q;
   assign memWren    = mem_wren_q;
   assign memAddress = mem_addr_q;
   assign memData    = mem_data_q;
   assign dropCount  = drop_cnt_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus pushes expected framebuffer
// writes into a queue, a negedge monitor pops and compares every write.
module tb_pixel_plot_sink;

   logic        clock = 1'b0;
   logic        reset;
   logic        plot;
   logic [8:0]  plotX;
   logic [7:0]  plotY;
   logic [2:0]  plotColour;
   logic        plotReady;
   logic        fillStart;
   logic [2:0]  fillColour;
   logic        fillBusy;
   logic        fillDone;
   logic [16:0] memAddress;
   logic [2:0]  memData;
   logic        memWren;
   logic [7:0]  dropCount;

   typedef struct packed {
      logic [16:0] addr;
      logic [2:0]  data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_exp;
   int  checks = 0;
   int  errors = 0;
   int  accepts = 0;
   int  writes_seen = 0;
   int  fill_done_cnt = 0;

   pixel_plot_sink dut (
      .clock      (clock),
      .reset      (reset),
      .plot       (plot),
      .plotX      (plotX),
      .plotY      (plotY),
      .plotColour (plotColour),
      .plotReady  (plotReady),
      .fillStart  (fillStart),
      .fillColour (fillColour),
      .fillBusy   (fillBusy),
      .fillDone   (fillDone),
      .memAddress (memAddress),
      .memData    (memData),
      .memWren    (memWren),
      .dropCount  (dropCount)
   );

   always #5 clock = ~clock;

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clock) begin
      if (fillDone === 1'b1) fill_done_cnt++;
      if (memWren !== 1'b0) begin
         writes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write wren=%b addr=%0d data=%0d", memWren, memAddress, memData);
         end else begin
            mon_exp = exp_q.pop_front();
            if (memWren !== 1'b1 || memAddress !== mon_exp.addr || memData !== mon_exp.data) begin
               errors++;
               $display("FAIL write_compare got addr=%0d data=%0d expected addr=%0d data=%0d",
                        memAddress, memData, mon_exp.addr, mon_exp.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hold a plot request until accepted; leaves plot asserted for back-to-back use.
   task automatic plot_px(input int x, input int y, input int c, output int waited);
      plot       = 1'b1;
      plotX      = 9'(x);
      plotY      = 8'(y);
      plotColour = 3'(c);
      waited     = 0;
      while (plotReady !== 1'b1 && waited < 100) begin
         step();
         waited++;
      end
      if (plotReady !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL plot_accept_timeout x=%0d y=%0d waited=%0d", x, y, waited);
         plot = 1'b0;
      end else begin
         if (x < 320 && y < 240) begin
            exp_q.push_back(wr_t'{addr: 17'(y * 320 + x), data: 3'(c)});
            accepts++;
         end
         step();
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      check(name, 32'(exp_q.size()), 0);
   endtask

   initial begin
      int w;
      int n;
      reset      = 1'b1;
      plot       = 1'b0;
      plotX      = '0;
      plotY      = '0;
      plotColour = '0;
      fillStart  = 1'b0;
      fillColour = '0;

      // Reset state
      step();
      step();
      check("rst_plotReady", 32'(plotReady), 0);
      check("rst_memWren", 32'(memWren), 0);
      check("rst_memAddress", 32'(memAddress), 0);
      check("rst_memData", 32'(memData), 0);
      check("rst_fillBusy", 32'(fillBusy), 0);
      check("rst_fillDone", 32'(fillDone), 0);
      check("rst_dropCount", 32'(dropCount), 0);
      reset = 1'b0;
      step();
      check("post_rst_plotReady", 32'(plotReady), 1);

      // 1: single plot, two-cycle latency, one-cycle write
      plot_px(10, 5, 5, w);
      plot = 1'b0;
      step();
      check("t1_wren_e1", 32'(memWren), 0);
      step();
      check("t1_wren_e2", 32'(memWren), 1);
      check("t1_addr", 32'(memAddress), 1610);
      check("t1_data", 32'(memData), 5);
      step();
      check("t1_wren_after", 32'(memWren), 0);
      wait_drain("t1_drain");

      // 2: back-to-back plots, consecutive in-order writes
      plot_px(0, 0, 1, w);
      check("t2_ready0", 32'(w), 0);
      plot_px(319, 239, 2, w);
      check("t2_ready1", 32'(w), 0);
      plot_px(1, 0, 3, w);
      check("t2_ready2", 32'(w), 0);
      plot = 1'b0;
      check("t2_addr0", {15'd0, memWren, memAddress}, {15'd0, 1'b1, 17'd0});
      step();
      check("t2_addr1", {15'd0, memWren, memAddress}, {15'd0, 1'b1, 17'd76799});
      step();
      check("t2_addr2", {15'd0, memWren, memAddress}, {15'd0, 1'b1, 17'd1});
      wait_drain("t2_drain");

      // 3: off-screen drops and saturation
      plot_px(320, 0, 7, w);
      plot_px(0, 240, 7, w);
      plot = 1'b0;
      repeat (4) step();
      check("t3_drop2", 32'(dropCount), 2);
      for (int i = 0; i < 257; i++) plot_px(400 + (i % 50), 10, 1, w);
      plot = 1'b0;
      repeat (4) step();
      check("t3_drop_sat", 32'(dropCount), 255);
      wait_drain("t3_no_writes");

      // 4: flood, outstanding bounded, every pixel written once
      for (int i = 0; i < 10; i++) begin
         plot_px(20 + i, i, i % 8, w);
         check("t4_ready", 32'(w), 0);
         checks++;
         if (accepts - writes_seen > 5) begin
            errors++;
            $display("FAIL t4_outstanding got %0d expected <=5", accepts - writes_seen);
         end
      end
      plot = 1'b0;
      wait_drain("t4_drain");

      // 5: fill with plots pending ahead of it
      fillColour = 3'b111;
      plot_px(5, 5, 1, w);
      plot_px(6, 5, 2, w);
      fillStart = 1'b1;
      plot_px(7, 5, 3, w);
      fillStart  = 1'b0;
      plot       = 1'b0;
      fillColour = 3'b000;
      for (int a = 0; a < 76800; a++) exp_q.push_back(wr_t'{addr: 17'(a), data: 3'b111});
      check("t5_busy", 32'(fillBusy), 1);
      check("t5_ready_low", 32'(plotReady), 0);
      n = 0;
      while (fillDone !== 1'b1 && n < 80000) begin
         step();
         n++;
      end
      check("t5_done_seen", 32'(fillDone), 1);
      step();
      check("t5_done_pulse", 32'(fillDone), 0);
      check("t5_busy_fall", 32'(fillBusy), 0);
      check("t5_ready_back", 32'(plotReady), 1);
      check("t5_queue_empty", 32'(exp_q.size()), 0);
      check("t5_done_count", 32'(fill_done_cnt), 1);

      // 6: reset aborts a fill at write #1000
      fillColour = 3'b010;
      fillStart  = 1'b1;
      for (int a = 0; a < 1000; a++) exp_q.push_back(wr_t'{addr: 17'(a), data: 3'b010});
      step();
      fillStart = 1'b0;
      n = 0;
      while (!(memWren === 1'b1 && memAddress == 17'd999) && n < 5000) begin
         step();
         n++;
      end
      check("t6_write999", {31'd0, memWren}, 1);
      reset = 1'b1;
      step();
      check("t6_wren", 32'(memWren), 0);
      check("t6_busy", 32'(fillBusy), 0);
      check("t6_drop", 32'(dropCount), 0);
      step();
      reset = 1'b0;
      step();
      check("t6_ready", 32'(plotReady), 1);
      plot_px(50, 60, 4, w);
      plot = 1'b0;
      wait_drain("t6_drain");
      repeat (3) step();
      check("t6_no_done", 32'(fill_done_cnt), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
